// File: rtl/minterm_matcher_pkg.sv
// rtl/minterm_matcher_pkg.sv - pattern record, reset constants and default minterm table
package minterm_pkg;

    localparam int MAX_IN_W = 16;

    typedef struct packed {
        logic [MAX_IN_W-1:0] val;
        logic [MAX_IN_W-1:0] care;
        logic                en;
    } pattern_t;

    localparam logic [MAX_IN_W-1:0] PAT_RST_VAL  = '0;
    localparam logic [MAX_IN_W-1:0] PAT_RST_CARE = '1;
    localparam logic                PAT_RST_EN   = 1'b0;

    // Table of the legacy fixed detectors, {X,Y,Z,K,M} order, every bit compared
    localparam int         N_DEFAULT    = 14;
    localparam logic [4:0] DEFAULT_CARE = 5'b11111;
    localparam logic [4:0] DEFAULT_MINTERMS [N_DEFAULT] = '{
        5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
        5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111
    };

    function automatic logic pat_hit(input pattern_t p, input logic [MAX_IN_W-1:0] v);
        return p.en && (((v ^ p.val) & p.care) == '0);
    endfunction

endpackage

// File: rtl/minterm_matcher_if.sv
// rtl/minterm_matcher_if.sv - pattern configuration write channel
interface minterm_matcher_if #(
    parameter int IN_W  = 5,
    parameter int N_PAT = 14,
    parameter int IDX_W = (N_PAT > 1) ? $clog2(N_PAT) : 1
);
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [IN_W-1:0]  cfg_val;
    logic [IN_W-1:0]  cfg_care;
    logic             cfg_en;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_idx, cfg_val, cfg_care, cfg_en,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_val, cfg_care, cfg_en,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/minterm_matcher_slot.sv
// rtl/minterm_matcher_slot.sv - one pattern slot: register, compare, hold qualify, edge, sticky
// Hit counter present only when MATCH_COUNT_EN is defined.
module minterm_slot
    import minterm_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int HOLD  = 2,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_q,
    input  logic            wr,
    input  logic [IN_W-1:0] wr_val,
    input  logic [IN_W-1:0] wr_care,
    input  logic            wr_en,
    input  logic            sticky_clr,
    output logic            match,
    output logic            match_pulse,
    output logic            sticky
`ifdef MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);
    localparam int             HW     = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [HW-1:0]  HOLD_C = HW'(HOLD);

    pattern_t      pat;
    logic [HW-1:0] cnt;
    logic          match_q;
    logic          raw_hit;

    assign raw_hit = pat_hit(pat, MAX_IN_W'(in_q));
    assign match   = (cnt == HOLD_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat         <= '{val: PAT_RST_VAL, care: PAT_RST_CARE, en: PAT_RST_EN};
            cnt         <= '0;
            match_q     <= 1'b0;
            match_pulse <= 1'b0;
            sticky      <= 1'b0;
        end else begin
            // A rewrite restarts qualification silently; history is kept
            if (wr) begin
                pat         <= '{val: MAX_IN_W'(wr_val), care: MAX_IN_W'(wr_care), en: wr_en};
                cnt         <= '0;
                match_q     <= 1'b0;
                match_pulse <= 1'b0;
            end else begin
                if (!raw_hit)
                    cnt <= '0;
                else if (cnt != HOLD_C)
                    cnt <= cnt + 1'b1;
                match_q     <= match;
                match_pulse <= match & ~match_q;
            end
            sticky <= match_pulse | (sticky & ~sticky_clr);
        end
    end

`ifdef MATCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            hit_cnt <= '0;
        else if (sticky_clr)
            hit_cnt <= CNT_W'(match_pulse);
        else if (match_pulse && (hit_cnt != '1))
            hit_cnt <= hit_cnt + 1'b1;
    end
`endif

endmodule

// File: rtl/minterm_matcher.sv
// rtl/minterm_matcher.sv - N_PAT programmable minterm matcher with hold qualification
// Optional per-slot hit counters and hit_cnt port under MATCH_COUNT_EN.
module minterm_matcher
    import minterm_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int N_PAT = 14,
    parameter int HOLD  = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_vec,
    minterm_matcher_if.slave  cfg,
    input  logic              sticky_clr,
    output logic [N_PAT-1:0]  match,
    output logic [N_PAT-1:0]  match_pulse,
    output logic [N_PAT-1:0]  sticky,
    output logic              any_match
`ifdef MATCH_COUNT_EN
    ,
    output logic [N_PAT*CNT_W-1:0] hit_cnt
`endif
);
    localparam int IDX_W = (N_PAT > 1) ? $clog2(N_PAT) : 1;

    if (HOLD < 1 || CNT_W < 1 || IN_W > MAX_IN_W) begin : g_illegal_params
    end

    logic [IN_W-1:0] in_q;
    logic            ready_q;
    logic            err_q;
    logic            accept;
    logic            in_range;

    assign accept   = cfg.cfg_we & ready_q;
    assign in_range = {1'b0, cfg.cfg_idx} < (IDX_W + 1)'(N_PAT);

    // Every accepted write, valid or not, costs one dead cycle on the channel
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q    <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            in_q    <= in_vec;
            ready_q <= ~accept;
            err_q   <= accept & ~in_range;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;
    assign any_match     = |match;

    for (genvar i = 0; i < N_PAT; i++) begin : g_slot
        logic wr;
        assign wr = accept & in_range & (cfg.cfg_idx == IDX_W'(i));

        minterm_slot #(
            .IN_W  (IN_W),
            .HOLD  (HOLD),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .in_q        (in_q),
            .wr          (wr),
            .wr_val      (cfg.cfg_val),
            .wr_care     (cfg.cfg_care),
            .wr_en       (cfg.cfg_en),
            .sticky_clr  (sticky_clr),
            .match       (match[i]),
            .match_pulse (match_pulse[i]),
            .sticky      (sticky[i])
`ifdef MATCH_COUNT_EN
            ,
            .hit_cnt     (hit_cnt[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_minterm_matcher.sv
// tb/tb_minterm_matcher.sv - directed table-driven bench for minterm_matcher
module tb_minterm_matcher;
    localparam int IN_W  = 5;
    localparam int N_PAT = 14;
    localparam int HOLD  = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  in_vec;
    logic             sticky_clr;
    logic [N_PAT-1:0] match;
    logic [N_PAT-1:0] match_pulse;
    logic [N_PAT-1:0] sticky;
    logic             any_match;
`ifdef MATCH_COUNT_EN
    logic [N_PAT*CNT_W-1:0] hit_cnt;
`endif

    minterm_matcher_if #(.IN_W(IN_W), .N_PAT(N_PAT)) cfg_bus ();

    minterm_matcher #(
        .IN_W (IN_W), .N_PAT (N_PAT), .HOLD (HOLD), .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vec      (in_vec),
        .cfg         (cfg_bus),
        .sticky_clr  (sticky_clr),
        .match       (match),
        .match_pulse (match_pulse),
        .sticky      (sticky),
        .any_match   (any_match)
`ifdef MATCH_COUNT_EN
        ,
        .hit_cnt     (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] vin;
        logic       clr;
        logic       m;
        logic       p;
        logic       s;
    } row_t;

    row_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] v, input logic c, input logic m, input logic p, input logic s);
        row_t r;
        r.vin = v; r.clr = c; r.m = m; r.p = p; r.s = s;
        tbl.push_back(r);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            in_vec     = tbl[i].vin;
            sticky_clr = tbl[i].clr;
            tick();
            sticky_clr = 1'b0;
            check($sformatf("row%0d match", i),  32'(match),       32'(tbl[i].m));
            check($sformatf("row%0d pulse", i),  32'(match_pulse), 32'(tbl[i].p));
            check($sformatf("row%0d sticky", i), 32'(sticky),      32'(tbl[i].s));
            check($sformatf("row%0d any", i),    32'(any_match),   32'(tbl[i].m));
        end
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [4:0] v, input logic [4:0] c,
                             input logic en, input logic exp_err);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_idx  = idx;
        cfg_bus.cfg_val  = v;
        cfg_bus.cfg_care = c;
        cfg_bus.cfg_en   = en;
        tick();
        cfg_bus.cfg_we = 1'b0;
        check("wr ready low", 32'(cfg_bus.cfg_ready), 32'd0);
        check("wr err",       32'(cfg_bus.cfg_err),   32'(exp_err));
        tick();
        check("wr ready back", 32'(cfg_bus.cfg_ready), 32'd1);
        check("wr err clear",  32'(cfg_bus.cfg_err),   32'd0);
    endtask

    task automatic check_hit(input string name, input int exp);
`ifdef MATCH_COUNT_EN
        check(name, 32'(hit_cnt[CNT_W-1:0]), 32'(exp));
`endif
    endtask

    int s0, s1, s2, s3, s4, s5a, s5b;

    initial begin
        // S0 idle with nothing enabled
        s0 = tbl.size();
        for (int i = 0; i < 4; i++) add(5'b00010, 0, 0, 0, 0);
        // S1 exact pattern 00010, one full episode
        s1 = tbl.size();
        add(5'b00010, 0, 0, 0, 0); add(5'b00010, 0, 0, 0, 0); add(5'b00010, 0, 1, 0, 0);
        add(5'b00010, 0, 1, 1, 0); add(5'b00010, 0, 1, 0, 1);
        add(5'b00000, 0, 1, 0, 1); add(5'b00000, 0, 0, 0, 1);
        // S2 care=11110, alternating LSB keeps match, 00110 breaks it
        s2 = tbl.size();
        add(5'b00010, 0, 0, 0, 1); add(5'b00011, 0, 0, 0, 1); add(5'b00010, 0, 1, 0, 1);
        add(5'b00011, 0, 1, 1, 1); add(5'b00010, 0, 1, 0, 1); add(5'b00011, 0, 1, 0, 1);
        add(5'b00110, 0, 1, 0, 1); add(5'b00010, 0, 0, 0, 1);
        // S3 clear, then toggling input never qualifies
        s3 = tbl.size();
        add(5'b00010, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) add((i % 2 == 0) ? 5'b00000 : 5'b00010, 0, 0, 0, 0);
        // S4 three separate episodes
        s4 = tbl.size();
        for (int e = 0; e < 3; e++) begin
            logic st;
            st = (e != 0);
            add(5'b00010, 0, 0, 0, st); add(5'b00010, 0, 0, 0, st);
            add(5'b00010, 0, 1, 0, st); add(5'b00010, 0, 1, 1, st);
            add(5'b00000, 0, 1, 0, 1);  add(5'b00000, 0, 0, 0, 1);
        end
        // S5 clear coincident with a pulse: set wins, then a plain clear
        s5a = tbl.size();
        add(5'b00010, 0, 0, 0, 1); add(5'b00010, 0, 0, 0, 1); add(5'b00010, 0, 1, 0, 1);
        add(5'b00010, 0, 1, 1, 1); add(5'b00010, 1, 1, 0, 1);
        s5b = tbl.size();
        add(5'b00010, 1, 1, 0, 0);

        rst = 1'b1; in_vec = 5'b00010; sticky_clr = 1'b0;
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_idx = '0; cfg_bus.cfg_val = '0;
        cfg_bus.cfg_care = '0; cfg_bus.cfg_en = 1'b0;
        tick();
        check("rst match",  32'(match),             32'd0);
        check("rst pulse",  32'(match_pulse),       32'd0);
        check("rst sticky", 32'(sticky),            32'd0);
        check("rst any",    32'(any_match),         32'd0);
        check("rst ready",  32'(cfg_bus.cfg_ready), 32'd1);
        check("rst err",    32'(cfg_bus.cfg_err),   32'd0);
        check_hit("rst hit", 0);
        tick();
        rst = 1'b0;

        run_rows(s0, s1);
        in_vec = 5'b00000;
        cfg_write(4'd0, 5'b00010, 5'b11111, 1'b1, 1'b0);
        run_rows(s1, s2);
        check_hit("hit after ep1", 1);

        in_vec = 5'b00000;
        cfg_write(4'd0, 5'b00010, 5'b11110, 1'b1, 1'b0);
        run_rows(s2, s3);
        check_hit("hit after care ep", 2);

        in_vec = 5'b00000;
        cfg_write(4'd0, 5'b00010, 5'b11111, 1'b1, 1'b0);
        run_rows(s3, s4);
        check_hit("hit after clr", 0);
        run_rows(s4, s5a);
        check_hit("hit three eps", 3);
        run_rows(s5a, s5b);
        check_hit("hit clr+pulse", 1);
        run_rows(s5b, tbl.size());
        check_hit("hit plain clr", 0);

        // Back-to-back: second strobe lands while ready is low and must be dropped
        in_vec = 5'b00000;
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_idx = 4'd1; cfg_bus.cfg_val = 5'b00111;
        cfg_bus.cfg_care = 5'b11111; cfg_bus.cfg_en = 1'b1;
        tick();
        check("b2b ready low", 32'(cfg_bus.cfg_ready), 32'd0);
        cfg_bus.cfg_idx = 4'd2;
        tick();
        cfg_bus.cfg_we = 1'b0;
        check("b2b ready back", 32'(cfg_bus.cfg_ready), 32'd1);
        in_vec = 5'b00111;
        for (int i = 0; i < 4; i++) tick();
        check("b2b match", 32'(match),     32'h0002);
        check("b2b any",   32'(any_match), 32'd1);

        cfg_write(4'd15, 5'b00111, 5'b11111, 1'b1, 1'b1);
        check("oor match", 32'(match),       32'h0002);
        check("oor pulse", 32'(match_pulse), 32'h0000);

        rst = 1'b1;
        tick();
        check("mid rst match",  32'(match),             32'd0);
        check("mid rst sticky", 32'(sticky),            32'd0);
        check("mid rst any",    32'(any_match),         32'd0);
        check("mid rst ready",  32'(cfg_bus.cfg_ready), 32'd1);
        rst = 1'b0;
        in_vec = 5'b00111;
        for (int i = 0; i < 4; i++) tick();
        check("post rst slot1", 32'(match), 32'd0);
        in_vec = 5'b00010;
        for (int i = 0; i < 4; i++) tick();
        check("post rst slot0", 32'(match), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/minterm_matcher.md
# minterm_matcher

Parametrised, registered successor to the fixed five-input minterm detectors. It compares a sampled input vector against N_PAT runtime-programmable patterns. Each pattern has a value, a don't-care mask and an enable. Outputs are qualified by a stability hold count, with rising-edge pulses, sticky flags and optional hit counters. It sits between input conditioning and the project's decision/display logic.

## Interface
- IN_W, 5: input vector width; bit order {X,Y,Z,K,M} for the default build, X = MSB.
- N_PAT, 14: number of pattern slots.
- HOLD, 2: consecutive matching samples required before `match` asserts; legal range ≥1.
- CNT_W, 8: width of each hit counter (used only with MATCH_COUNT_EN).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vec  in  IN_W  raw input vector, sampled every cycle.
- cfg_we  in  1  pattern write strobe.
- cfg_idx  in  $clog2(N_PAT)  slot to write.
- cfg_val  in  IN_W  pattern value.
- cfg_care  in  IN_W  1 = bit compared, 0 = don't care.
- cfg_en  in  1  slot enable.
- cfg_ready  out  1  write accepted when cfg_we & cfg_ready.
- cfg_err  out  1  one-cycle pulse: accepted write to cfg_idx ≥ N_PAT.
- match  out  N_PAT  qualified level match per slot.
- match_pulse  out  N_PAT  one-cycle pulse on each match rising edge.
- sticky  out  N_PAT  latched match_pulse history.
- sticky_clr  in  1  clears all sticky bits (and hit counters).
- any_match  out  1  OR of match.
- hit_cnt  out  N_PAT*CNT_W  per-slot counters, slot i at [i*CNT_W +: CNT_W]; present only with MATCH_COUNT_EN.

## Operation
- Reset: every slot has val=0, care=all-ones, en=0; in_q=0; hold counters=0. match, match_pulse, sticky, any_match, cfg_err and hit_cnt are 0. cfg_ready=1.
- Input stage: in_q <= in_vec every cycle.
- Raw hit, slot i: en[i] & (((in_q ^ val[i]) & care[i]) == 0).
- Hold counter, slot i:
  - Width $clog2(HOLD+1).
  - On a raw hit, saturating increment to HOLD.
  - On a miss, cleared to 0.
  - match[i] = (cnt[i] == HOLD), taken from the register, so the output is glitch-free.
- match_pulse[i]: registered match[i] & ~match_q[i]; exactly one cycle per rising edge.
- sticky[i]:
  - Set by match_pulse[i].
  - Cleared by sticky_clr.
  - If set and clear coincide, set wins.
- Config writes:
  - An accepted write updates the slot on the next edge.
  - The same write clears that slot's hold counter, match and match_q, without generating a pulse.
  - sticky and hit_cnt are unchanged by a write.
  - cfg_ready drops for exactly one cycle after an accepted write; cfg_we while cfg_ready=0 is ignored.
  - Out-of-range cfg_idx writes nothing, pulses cfg_err and still drops cfg_ready.
- rst mid-operation: all state returns to reset values on that edge, including programmed patterns.

## Timing
- Vector sampled into in_q at edge t0 and matching through t0+HOLD-1:
  - match rises after edge t0+HOLD.
  - match_pulse is high for the cycle after edge t0+HOLD+1.
  - sticky is set after edge t0+HOLD+2.
- Any single non-matching sample clears the counter, and match falls on the following edge.
- Config write at edge w: new pattern is compared from edge w+1. Next write accepted at edge w+2.

## Configuration
- MATCH_COUNT_EN defined:
  - Per-slot CNT_W counter increments on match_pulse and saturates at all-ones.
  - sticky_clr zeroes the counters.
  - Clear plus pulse in the same cycle gives a count of 1.
  - hit_cnt port exists.
- MATCH_COUNT_EN undefined: no counters, no hit_cnt port; all other behaviour identical.

## Structure
- Package minterm_pkg:
  - pattern_t struct {val, care, en}.
  - Reset constants PAT_RST_VAL=0, PAT_RST_CARE='1, PAT_RST_EN=0.
  - Default-table localparams reproducing the existing 14 minterms, e.g. slot 0 = 5'b00010, slot 1 = 5'b00011, all care bits set.
- Sub-module minterm_slot holds one slot's pattern register, compare, hold counter, edge detect, sticky and optional counter. The top generates N_PAT instances and the config decode.

## Test plan
- Reset then idle with in_vec=5'b00010: no slot enabled, so match=0, sticky=0, any_match=0 throughout.
- Program slot 0 = {00010, 11111, en=1}, HOLD=2. Drive 00010 for 5 cycles: match[0] rises exactly 2 edges after sampling, match_pulse[0] lasts one cycle, sticky[0]=1.
- Slot 0 care=11110. Alternate 00010 and 00011 each cycle: match[0] stays high. Then drive 00110 for one cycle: match[0] drops after the next edge.
- Toggle 00010 / 00000 every cycle with HOLD=2: match[0] never asserts and sticky[0] stays 0.
- Back-to-back cfg_we: second write ignored while cfg_ready=0. Write with cfg_idx=15 (N_PAT=14): cfg_err pulses for one cycle and no slot changes.
- With MATCH_COUNT_EN: three separate match episodes give hit_cnt slot 0 = 3. sticky_clr coincident with a fourth pulse gives hit_cnt=1 and sticky=1.
